// File: rtl/rv_ctrl_pkg.sv
// Shared opcode constants, ALU-op encodings and the packed control word
// used by the RV32IM ID/EX control path.
package rv_ctrl_pkg;

  localparam int OPC_W    = 7;
  localparam int ALU_OP_W = 2;

  localparam logic [OPC_W-1:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_IALU   = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
  localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [ALU_OP_W-1:0] ALU_OP_ADD    = 2'b00;
  localparam logic [ALU_OP_W-1:0] ALU_OP_BRANCH = 2'b01;
  localparam logic [ALU_OP_W-1:0] ALU_OP_RTYPE  = 2'b10;
  localparam logic [ALU_OP_W-1:0] ALU_OP_ITYPE  = 2'b11;

  typedef struct packed {
    logic                reg_write;
    logic                mem_read;
    logic                mem_write;
    logic                mem_to_reg;
    logic                alu_src;
    logic                branch;
    logic                jump;
    logic [ALU_OP_W-1:0] alu_op;
    logic                illegal;
  } ctrl_t;

  // Bubble: every control deasserted, including illegal.
  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/control_decode.sv
// Purely combinational major-opcode decoder; unused fields are forced to 0
// so no X ever leaves this block.
module control_decode
  import rv_ctrl_pkg::*;
(
  input  logic [OPC_W-1:0] opcode,
  output ctrl_t            ctrl
);

  always_comb begin
    ctrl = CTRL_NOP;
    unique case (opcode)
      OPC_RTYPE: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALU_OP_RTYPE;
      end
      OPC_IALU: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = ALU_OP_ITYPE;
      end
      OPC_LOAD: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.alu_src    = 1'b1;
      end
      OPC_STORE: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
      end
      OPC_BRANCH: begin
        ctrl.branch = 1'b1;
        ctrl.alu_op = ALU_OP_BRANCH;
      end
      OPC_JAL, OPC_JALR: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.jump      = 1'b1;
      end
      OPC_LUI, OPC_AUIPC: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
      end
      default: ctrl.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// ID/EX control register: decodes the ID-stage opcode and presents the
// controls to EX one cycle later, with flush-over-stall hazard handling.
module control_unit
  import rv_ctrl_pkg::*;
#(
  parameter int ALU_OP_W = 2,
  parameter int OPC_W    = 7
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPC_W-1:0]    opcode,
  input  logic                stall,
  input  logic                flush,
  output logic                reg_write,
  output logic                mem_read,
  output logic                mem_write,
  output logic                mem_to_reg,
  output logic                alu_src,
  output logic                branch,
  output logic                jump,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                illegal
);

  ctrl_t decoded;
  ctrl_t ctrl_reg;
  ctrl_t ctrl_next;

  control_decode u_decode (
    .opcode (opcode),
    .ctrl   (decoded)
  );

  // Flush beats stall so a squashed instruction can never be held in EX.
  always_comb begin
    ctrl_next = decoded;
    if (flush) begin
      ctrl_next = CTRL_NOP;
    end else if (stall) begin
      ctrl_next = ctrl_reg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_reg <= CTRL_NOP;
    end else begin
      ctrl_reg <= ctrl_next;
    end
  end

  assign reg_write  = ctrl_reg.reg_write;
  assign mem_read   = ctrl_reg.mem_read;
  assign mem_write  = ctrl_reg.mem_write;
  assign mem_to_reg = ctrl_reg.mem_to_reg;
  assign alu_src    = ctrl_reg.alu_src;
  assign branch     = ctrl_reg.branch;
  assign jump       = ctrl_reg.jump;
  assign alu_op     = ctrl_reg.alu_op;
  assign illegal    = ctrl_reg.illegal;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: decode table, illegal opcodes, async
// reset, stall hold and flush priority, plus per-cycle sanity on outputs.
module tb_control_unit;

  logic       clk;
  logic       rst_n;
  logic [6:0] opcode;
  logic       stall;
  logic       flush;
  logic       reg_write, mem_read, mem_write, mem_to_reg;
  logic       alu_src, branch, jump, illegal;
  logic [1:0] alu_op;

  int checks_total;
  int checks_passed;
  bit armed;

  // Packed view: reg_write,mem_read,mem_write,mem_to_reg,alu_src,branch,jump,alu_op[1:0],illegal
  logic [9:0] obs;
  assign obs = {reg_write, mem_read, mem_write, mem_to_reg, alu_src,
                branch, jump, alu_op, illegal};

  localparam logic [9:0] E_RTYPE  = 10'b1_0_0_0_0_0_0_10_0;
  localparam logic [9:0] E_IALU   = 10'b1_0_0_0_1_0_0_11_0;
  localparam logic [9:0] E_LOAD   = 10'b1_1_0_1_1_0_0_00_0;
  localparam logic [9:0] E_STORE  = 10'b0_0_1_0_1_0_0_00_0;
  localparam logic [9:0] E_BRANCH = 10'b0_0_0_0_0_1_0_01_0;
  localparam logic [9:0] E_JUMP   = 10'b1_0_0_0_1_0_1_00_0;
  localparam logic [9:0] E_UPPER  = 10'b1_0_0_0_1_0_0_00_0;
  localparam logic [9:0] E_ILL    = 10'b0_0_0_0_0_0_0_00_1;
  localparam logic [9:0] E_ZERO   = 10'b0;

  logic [6:0] opc_tab [9];
  logic [9:0] exp_tab [9];

  control_unit #(.ALU_OP_W(2), .OPC_W(7)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .stall      (stall),
    .flush      (flush),
    .reg_write  (reg_write),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_to_reg (mem_to_reg),
    .alu_src    (alu_src),
    .branch     (branch),
    .jump       (jump),
    .alu_op     (alu_op),
    .illegal    (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [9:0] got, input logic [9:0] want);
    checks_total++;
    assert (got === want) begin
      checks_passed++;
    end else begin
      $error("FAIL %s: observed %b expected %b", tag, got, want);
    end
  endtask

  // Drive inputs on a falling edge, let one rising edge pass, sample on the next falling edge.
  task automatic step(input logic [6:0] opc, input logic stl, input logic fls);
    opcode = opc;
    stall  = stl;
    flush  = fls;
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (armed) begin
      check("mem_rd_wr_exclusive", {9'b0, mem_read & mem_write}, 10'b0);
      check("no_x_outputs", {9'b0, $isunknown(obs)}, 10'b0);
    end
  end

  initial begin
    checks_total  = 0;
    checks_passed = 0;
    armed  = 1'b0;
    rst_n  = 1'b0;
    opcode = 7'b0110011;
    stall  = 1'b0;
    flush  = 1'b0;

    opc_tab[0] = 7'b0110011; exp_tab[0] = E_RTYPE;
    opc_tab[1] = 7'b0010011; exp_tab[1] = E_IALU;
    opc_tab[2] = 7'b0000011; exp_tab[2] = E_LOAD;
    opc_tab[3] = 7'b0100011; exp_tab[3] = E_STORE;
    opc_tab[4] = 7'b1100011; exp_tab[4] = E_BRANCH;
    opc_tab[5] = 7'b1101111; exp_tab[5] = E_JUMP;
    opc_tab[6] = 7'b1100111; exp_tab[6] = E_JUMP;
    opc_tab[7] = 7'b0110111; exp_tab[7] = E_UPPER;
    opc_tab[8] = 7'b0010111; exp_tab[8] = E_UPPER;

    repeat (2) @(negedge clk);
    check("reset_state", obs, E_ZERO);
    rst_n = 1'b1;
    step(7'b0110011, 1'b0, 1'b0);
    check("first_after_reset_rtype", obs, E_RTYPE);
    armed = 1'b1;

    for (int i = 0; i < 9; i++) begin
      step(opc_tab[i], 1'b0, 1'b0);
      check($sformatf("decode_%b", opc_tab[i]), obs, exp_tab[i]);
      $display("decode opcode=%b outputs=%b", opc_tab[i], obs);
    end

    step(7'b0000000, 1'b0, 1'b0);
    check("illegal_0000000", obs, E_ILL);
    step(7'b1111111, 1'b0, 1'b0);
    check("illegal_1111111", obs, E_ILL);

    // Asynchronous reset asserted and released between clock edges.
    step(7'b0110011, 1'b0, 1'b0);
    check("pre_reset_rtype", obs, E_RTYPE);
    #2 rst_n = 1'b0;
    #1 check("async_reset_immediate", obs, E_ZERO);
    @(negedge clk);
    check("reset_held", obs, E_ZERO);
    #2 rst_n = 1'b1;
    #1 check("reset_release_no_edge", obs, E_ZERO);
    @(negedge clk);
    check("post_release_rtype", obs, E_RTYPE);
    $display("reset sequence outputs=%b", obs);

    // Stall holds a store while the ID opcode moves on to R-type.
    step(7'b0100011, 1'b0, 1'b0);
    check("stall_setup_store", obs, E_STORE);
    for (int i = 0; i < 3; i++) begin
      step(7'b0110011, 1'b1, 1'b0);
      check($sformatf("stall_hold_%0d", i), obs, E_STORE);
      $display("stall cycle %0d outputs=%b", i, obs);
    end
    step(7'b0110011, 1'b0, 1'b0);
    check("stall_release_rtype", obs, E_RTYPE);

    // Flush together with stall must still yield a bubble.
    step(7'b0000011, 1'b1, 1'b1);
    check("flush_over_stall", obs, E_ZERO);
    $display("flush+stall outputs=%b", obs);
    step(7'b0000011, 1'b0, 1'b0);
    check("after_flush_load", obs, E_LOAD);
    step(7'b1100011, 1'b0, 1'b1);
    check("flush_only", obs, E_ZERO);
    step(7'b1100011, 1'b0, 1'b0);
    check("after_flush_branch", obs, E_BRANCH);

    armed = 1'b0;
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
